alu_issue_arbiter: RTL and testbench

- Shares one combinational ALU datapath (ADD/SUB/MUL on 32-bit operands) between two requesters.
- Arbitrates round-robin and registers the winning instruction onto the ALU inputs.
- Holds MUL for a configurable multicycle window, then returns the result tagged with the requester id over a valid/ready response channel.
- Sits between the instruction-issue logic and the ALU instance.

---
 rtl/alu_issue_arbiter_if.sv | 48 ++++
 rtl/alu_issue_arbiter.sv | 105 ++++++++++
 tb/tb_alu_issue_arbiter.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_issue_arbiter_if.sv
// Request, ALU-side and response signals shared between the issue logic,
// the arbiter and the ALU instance.
interface alu_issue_arbiter_if #(
    parameter int WIDTH = 32
);
    logic             req0_valid;
    logic             req0_ready;
    logic [1:0]       req0_opcode;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;

    logic             req1_valid;
    logic             req1_ready;
    logic [1:0]       req1_opcode;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;

    logic [1:0]       alu_opcode;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [WIDTH-1:0] alu_result;

    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_id;
    logic [WIDTH-1:0] rsp_result;
    logic             rsp_error;

    // Arbiter side
    modport slave (
        input  req0_valid, req0_opcode, req0_a, req0_b,
        input  req1_valid, req1_opcode, req1_a, req1_b,
        input  alu_result, rsp_ready,
        output req0_ready, req1_ready,
        output alu_opcode, alu_a, alu_b,
        output rsp_valid, rsp_id, rsp_result, rsp_error
    );

    // Requester / ALU / consumer side
    modport master (
        output req0_valid, req0_opcode, req0_a, req0_b,
        output req1_valid, req1_opcode, req1_a, req1_b,
        output alu_result, rsp_ready,
        input  req0_ready, req1_ready,
        input  alu_opcode, alu_a, alu_b,
        input  rsp_valid, rsp_id, rsp_result, rsp_error
    );
endinterface

// File: rtl/alu_issue_arbiter.sv
// Round-robin issue arbiter sharing one combinational ALU between two
// requesters; holds operands for the multicycle MUL window and returns the
// tagged result over a valid/ready response channel.
module alu_issue_arbiter #(
    parameter int WIDTH       = 32,
    parameter int MUL_LATENCY = 3
) (
    input  logic                clock,
    input  logic                reset_n,
    alu_issue_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    localparam logic [1:0] OP_MUL  = 2'd2;
    localparam logic [1:0] OP_ILL  = 2'd3;
    localparam logic [3:0] MUL_CNT = 4'(MUL_LATENCY);

    state_t           state;
    state_t           state_nxt;
    logic             last_grant;
    logic [3:0]       cnt;

    logic             any_valid;
    logic             grant;
    logic             accept;
    logic [1:0]       sel_op;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;

    // Round-robin choice: the requester that did not win last time breaks ties
    always_comb begin
        any_valid = bus.req0_valid | bus.req1_valid;
        if (bus.req0_valid && bus.req1_valid) begin
            grant = ~last_grant;
        end else begin
            grant = bus.req1_valid;
        end
        sel_op = grant ? bus.req1_opcode : bus.req0_opcode;
        sel_a  = grant ? bus.req1_a      : bus.req0_a;
        sel_b  = grant ? bus.req1_b      : bus.req0_b;
    end

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept)        state_nxt = (sel_op == OP_ILL) ? RESP : EXEC;
            EXEC: if (cnt == 4'd1)   state_nxt = RESP;
            RESP: if (bus.rsp_ready) state_nxt = IDLE;
            default:                 state_nxt = IDLE;
        endcase
    end

    // Handshake outputs: ready only while idle, valid only while responding
    always_comb begin
        accept         = (state == IDLE) && any_valid;
        bus.req0_ready = accept && !grant;
        bus.req1_ready = accept && grant;
        bus.rsp_valid  = (state == RESP);
    end

    // Instruction capture, multicycle counter and result capture
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            bus.alu_opcode <= '0;
            bus.alu_a      <= '0;
            bus.alu_b      <= '0;
            bus.rsp_result <= '0;
            bus.rsp_id     <= 1'b0;
            bus.rsp_error  <= 1'b0;
            last_grant     <= 1'b1;
            cnt            <= '0;
        end else begin
            if (accept) begin
                bus.alu_opcode <= sel_op;
                bus.alu_a      <= sel_a;
                bus.alu_b      <= sel_b;
                bus.rsp_id     <= grant;
                last_grant     <= grant;
                if (sel_op == OP_ILL) begin
                    bus.rsp_result <= '0;
                    bus.rsp_error  <= 1'b1;
                end else begin
                    cnt <= (sel_op == OP_MUL) ? MUL_CNT : 4'd1;
                end
            end
            if (state == EXEC) begin
                cnt <= cnt - 4'd1;
                if (cnt == 4'd1) begin
                    bus.rsp_result <= bus.alu_result;
                    bus.rsp_error  <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_alu_issue_arbiter.sv
// Bench for alu_issue_arbiter: directed scenarios followed by random traffic,
// all checked against a transaction-level reference of the arbiter.
module tb_alu_issue_arbiter;
    localparam int W   = 32;
    localparam int LAT = 3;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;

    always #5 clock = ~clock;

    alu_issue_arbiter_if #(.WIDTH(W)) bus ();

    alu_issue_arbiter #(.WIDTH(W), .MUL_LATENCY(LAT)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // Combinational ALU standing in for the real datapath
    always_comb begin
        case (bus.alu_opcode)
            2'd0:    bus.alu_result = bus.alu_a + bus.alu_b;
            2'd1:    bus.alu_result = bus.alu_a - bus.alu_b;
            2'd2:    bus.alu_result = bus.alu_a * bus.alu_b;
            default: bus.alu_result = '0;
        endcase
    end

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    // Reference: one outstanding transaction with a due cycle
    bit          pend   = 1'b0;
    bit          p_id   = 1'b0;
    bit          p_err  = 1'b0;
    logic [W-1:0] p_res = '0;
    int          p_due  = 0;
    bit          last_g = 1'b1;
    logic [1:0]  m_op   = '0;
    logic [W-1:0] m_a   = '0;
    logic [W-1:0] m_b   = '0;
    bit          keep0  = 1'b0;
    bit          keep1  = 1'b0;

    int acc_cyc[$];
    bit acc_id[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [W-1:0] ref_res(input logic [1:0] op, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
        case (op)
            2'd0:    return a + b;
            2'd1:    return a - b;
            2'd2:    return a * b;
            default: return '0;
        endcase
    endfunction

    function automatic logic [W-1:0] rnd_operand();
        case ($urandom_range(0, 3))
            0:       return '0;
            1:       return '1;
            default: return W'($urandom);
        endcase
    endfunction

    // One clock cycle: check outputs against the reference, advance it,
    // and retire any requester that was accepted.
    task automatic step();
        bit v0, v1, g, acc, rv;
        logic [1:0] op;
        logic [W-1:0] a, b;
        int lat;
        #1;
        v0  = bus.req0_valid;
        v1  = bus.req1_valid;
        acc = !pend && (v0 || v1);
        g   = (v0 && v1) ? !last_g : v1;
        chk("req0_ready", bus.req0_ready, acc && !g);
        chk("req1_ready", bus.req1_ready, acc && g);
        rv = pend && (cyc >= p_due);
        chk("rsp_valid", bus.rsp_valid, rv);
        if (rv) begin
            chk("rsp_id", bus.rsp_id, p_id);
            chk("rsp_result", bus.rsp_result, p_res);
            chk("rsp_error", bus.rsp_error, p_err);
        end
        chk("alu_opcode", bus.alu_opcode, m_op);
        chk("alu_a", bus.alu_a, m_a);
        chk("alu_b", bus.alu_b, m_b);
        if (rv && bus.rsp_ready) pend = 1'b0;
        if (acc) begin
            op  = g ? bus.req1_opcode : bus.req0_opcode;
            a   = g ? bus.req1_a : bus.req0_a;
            b   = g ? bus.req1_b : bus.req0_b;
            lat = (op == 2'd3) ? 1 : (op == 2'd2) ? LAT + 1 : 2;
            pend   = 1'b1;
            p_id   = g;
            p_err  = (op == 2'd3);
            p_res  = p_err ? '0 : ref_res(op, a, b);
            p_due  = cyc + lat;
            last_g = g;
            m_op   = op;
            m_a    = a;
            m_b    = b;
        end
        @(negedge clock);
        cyc++;
        if (acc) begin
            if (!g && !keep0) bus.req0_valid = 1'b0;
            if (g && !keep1)  bus.req1_valid = 1'b0;
        end
    endtask

    initial begin
        bus.req0_valid = 0; bus.req0_opcode = 0; bus.req0_a = 0; bus.req0_b = 0;
        bus.req1_valid = 0; bus.req1_opcode = 0; bus.req1_a = 0; bus.req1_b = 0;
        bus.rsp_ready  = 1;

        // Reset state
        @(negedge clock);
        @(negedge clock);
        #1;
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_rsp_id", bus.rsp_id, 0);
        chk("rst_rsp_result", bus.rsp_result, 0);
        chk("rst_rsp_error", bus.rsp_error, 0);
        chk("rst_alu_opcode", bus.alu_opcode, 0);
        chk("rst_alu_a", bus.alu_a, 0);
        chk("rst_req0_ready", bus.req0_ready, 0);
        reset_n = 1'b1;
        @(negedge clock);
        cyc++;

        // ADD 5+7 from requester 0
        bus.req0_valid = 1; bus.req0_opcode = 2'd0; bus.req0_a = 5; bus.req0_b = 7;
        #1 chk("t1_ready", bus.req0_ready, 1);
        step();
        step();
        #1;
        chk("t1_valid", bus.rsp_valid, 1);
        chk("t1_id", bus.rsp_id, 0);
        chk("t1_result", bus.rsp_result, 12);
        chk("t1_error", bus.rsp_error, 0);
        step();

        // SUB 0-1 wraps
        bus.req1_valid = 1; bus.req1_opcode = 2'd1; bus.req1_a = 0; bus.req1_b = 1;
        step();
        step();
        #1;
        chk("t2_result", bus.rsp_result, 32'hFFFF_FFFF);
        chk("t2_id", bus.rsp_id, 1);
        step();

        // MUL 6*7 held for LAT cycles
        bus.req0_valid = 1; bus.req0_opcode = 2'd2; bus.req0_a = 6; bus.req0_b = 7;
        step();
        for (int i = 0; i < LAT; i++) begin
            #1;
            chk("t3_alu_a", bus.alu_a, 6);
            chk("t3_alu_b", bus.alu_b, 7);
            chk("t3_not_yet", bus.rsp_valid, 0);
            step();
        end
        #1;
        chk("t3_valid", bus.rsp_valid, 1);
        chk("t3_result", bus.rsp_result, 42);
        step();

        // Fairness: both continuously valid
        keep0 = 1; keep1 = 1;
        bus.req0_valid = 1; bus.req0_opcode = 2'd0; bus.req0_a = 1;  bus.req0_b = 2;
        bus.req1_valid = 1; bus.req1_opcode = 2'd0; bus.req1_a = 10; bus.req1_b = 20;
        for (int i = 0; i < 12; i++) begin
            #1;
            if (bus.req0_ready || bus.req1_ready) begin
                acc_cyc.push_back(cyc);
                acc_id.push_back(bus.req1_ready);
            end
            step();
        end
        chk("t4_accepts", acc_cyc.size(), 4);
        for (int i = 1; i < acc_cyc.size(); i++) begin
            chk("t4_alternate", acc_id[i], !acc_id[i-1]);
            chk("t4_spacing", acc_cyc[i] - acc_cyc[i-1], 3);
        end
        keep0 = 0; keep1 = 0;
        bus.req0_valid = 0; bus.req1_valid = 0;
        step();
        step();

        // Backpressure, then an illegal opcode
        bus.rsp_ready = 0;
        bus.req1_valid = 1; bus.req1_opcode = 2'd0; bus.req1_a = 100; bus.req1_b = 23;
        step();
        step();
        bus.req0_valid = 1; bus.req0_opcode = 2'd3; bus.req0_a = 9; bus.req0_b = 9;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("t5_stall_valid", bus.rsp_valid, 1);
            chk("t5_stall_result", bus.rsp_result, 123);
            chk("t5_stall_id", bus.rsp_id, 1);
            chk("t5_stall_ready0", bus.req0_ready, 0);
            step();
        end
        bus.rsp_ready = 1;
        step();
        #1 chk("t5_ill_ready", bus.req0_ready, 1);
        step();
        #1;
        chk("t5_ill_valid", bus.rsp_valid, 1);
        chk("t5_ill_error", bus.rsp_error, 1);
        chk("t5_ill_result", bus.rsp_result, 0);
        chk("t5_ill_id", bus.rsp_id, 0);
        step();

        // Reset in the 2nd MUL cycle
        bus.req0_valid = 1; bus.req0_opcode = 2'd2; bus.req0_a = 3; bus.req0_b = 4;
        step();
        step();
        #2 reset_n = 1'b0;
        #1;
        chk("t6_rsp_valid", bus.rsp_valid, 0);
        chk("t6_alu_opcode", bus.alu_opcode, 0);
        chk("t6_alu_a", bus.alu_a, 0);
        chk("t6_alu_b", bus.alu_b, 0);
        chk("t6_rsp_result", bus.rsp_result, 0);
        chk("t6_rsp_id", bus.rsp_id, 0);
        chk("t6_ready", bus.req0_ready | bus.req1_ready, 0);
        pend = 0; last_g = 1; m_op = '0; m_a = '0; m_b = '0;
        @(negedge clock);
        cyc++;
        reset_n = 1'b1;
        @(negedge clock);
        cyc++;
        bus.req0_valid = 1; bus.req0_opcode = 2'd0; bus.req0_a = 2; bus.req0_b = 3;
        step();
        step();
        #1;
        chk("t6_after_valid", bus.rsp_valid, 1);
        chk("t6_after_result", bus.rsp_result, 5);
        step();

        // Random traffic
        for (int i = 0; i < 300; i++) begin
            if (!bus.req0_valid) begin
                if ($urandom_range(0, 2) == 0) begin
                    bus.req0_valid  = 1;
                    bus.req0_opcode = 2'($urandom_range(0, 3));
                    bus.req0_a      = rnd_operand();
                    bus.req0_b      = rnd_operand();
                end
            end else if ($urandom_range(0, 15) == 0) begin
                bus.req0_valid = 0;
            end
            if (!bus.req1_valid) begin
                if ($urandom_range(0, 2) == 0) begin
                    bus.req1_valid  = 1;
                    bus.req1_opcode = 2'($urandom_range(0, 3));
                    bus.req1_a      = rnd_operand();
                    bus.req1_b      = rnd_operand();
                end
            end else if ($urandom_range(0, 15) == 0) begin
                bus.req1_valid = 0;
            end
            bus.rsp_ready = ($urandom_range(0, 3) != 0);
            step();
        end

        bus.req0_valid = 0; bus.req1_valid = 0; bus.rsp_ready = 1;
        for (int i = 0; i < 10; i++) step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
